matrix_mult_tile_acc: RTL and testbench

Parametrised tiled matrix-multiply engine: computes O(M×N) = Σ_tiles I_t(M×K)·W_t(K×N) with K·N parallel multipliers, one output row per cycle, accumulating across `tile_num` tiles in an internal accumulator RAM. After the final tile, results are post-processed (round, shift, optional ReLU, saturate) and streamed out row-major over a valid/ready interface. Successor to the fixed-size weight-fixed multiplier in the conv datapath; feeds the layer output writer.

---
 rtl/matrix_mult_tile_acc.sv | 253 +++++++++++++++++++++++++
 tb/tb_matrix_mult_tile_acc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_tile_acc.sv
// Tiled I(MxK) * W(KxN) engine: one output row per cycle, accumulated over tile_num
// tiles in a row-wide accumulator RAM, then rounded/shifted/ReLU'd/saturated and streamed.
module matrix_mult_tile_acc #(
  parameter int M      = 4,
  parameter int K      = 3,
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int TILE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_we,
  input  logic [$clog2(K*N)-1:0]     w_addr,
  input  logic signed [DATA_W-1:0]   w_din,
  input  logic                       fm_we,
  input  logic [$clog2(M*K)-1:0]     fm_addr,
  input  logic signed [DATA_W-1:0]   fm_din,
  input  logic [TILE_W-1:0]          tile_num,
  input  logic                       relu_en,
  input  logic                       start,
  input  logic                       clear,
  output logic                       busy,
  output logic                       tile_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_last
);

  localparam int WA_W   = $clog2(K*N);
  localparam int FA_W   = $clog2(M*K);
  localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;
  localparam int COL_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = 2*DATA_W;

  localparam logic signed [ACC_W:0] OUT_MAX =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t            state_reg, state_next;
  logic [TILE_W-1:0] tile_cnt_reg, tile_cnt_next;
  logic [TILE_W-1:0] tile_tot_reg, tile_tot_next;
  logic              relu_reg, relu_next;
  logic              issue_en_reg, issue_en_next;
  logic [ROW_W-1:0]  issue_row_reg, issue_row_next;
  logic [ROW_W-1:0]  out_row_reg, out_row_next;
  logic [COL_W-1:0]  out_col_reg, out_col_next;

  logic              s0_valid_reg, s1_valid_reg;
  logic [ROW_W-1:0]  s0_row_reg, s1_row_reg;

  logic signed [DATA_W-1:0] w_mem [K*N];
  logic signed [DATA_W-1:0] fm_mem [M*K];
  logic signed [DATA_W-1:0] fm_row_reg [K];
  logic signed [PROD_W-1:0] prod_reg [K][N];

  logic [N*ACC_W-1:0] acc_mem [M];
  logic [N*ACC_W-1:0] acc_rd_reg;
  logic [N*ACC_W-1:0] acc_wr_row;
  logic [ROW_W-1:0]   acc_rd_addr;

  logic start_acc, last_row_done, last_tile, out_hs, out_end, out_row_last, out_col_last;

  assign start_acc     = (state_reg == IDLE) && start && !clear;
  assign last_row_done = s1_valid_reg && (s1_row_reg == ROW_W'(M-1));
  assign last_tile     = ({1'b0, tile_cnt_reg} + (TILE_W+1)'(1)) == {1'b0, tile_tot_reg};
  assign out_row_last  = (out_row_reg == ROW_W'(M-1));
  assign out_col_last  = (out_col_reg == COL_W'(N-1));
  assign out_hs        = (state_reg == OUTPUT) && out_ready;
  assign out_end       = out_hs && out_row_last && out_col_last;

  // State, counters and pipeline valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tile_cnt_reg  <= '0;
      tile_tot_reg  <= TILE_W'(1);
      relu_reg      <= 1'b0;
      issue_en_reg  <= 1'b0;
      issue_row_reg <= '0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
      s0_valid_reg  <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s0_row_reg    <= '0;
      s1_row_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      tile_cnt_reg  <= tile_cnt_next;
      tile_tot_reg  <= tile_tot_next;
      relu_reg      <= relu_next;
      issue_en_reg  <= issue_en_next;
      issue_row_reg <= issue_row_next;
      out_row_reg   <= out_row_next;
      out_col_reg   <= out_col_next;
      s0_valid_reg  <= issue_en_reg && !clear;
      s1_valid_reg  <= s0_valid_reg && !clear;
      s0_row_reg    <= issue_row_reg;
      s1_row_reg    <= s0_row_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = COMPUTE;
        COMPUTE: if (last_row_done) state_next = last_tile ? OUTPUT : IDLE;
        OUTPUT:  if (out_end) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tile_cnt_next  = tile_cnt_reg;
    tile_tot_next  = tile_tot_reg;
    relu_next      = relu_reg;
    issue_en_next  = issue_en_reg;
    issue_row_next = issue_row_reg;
    out_row_next   = out_row_reg;
    out_col_next   = out_col_reg;
    if (clear) begin
      tile_cnt_next  = '0;
      issue_en_next  = 1'b0;
      issue_row_next = '0;
      out_row_next   = '0;
      out_col_next   = '0;
    end else begin
      if (start_acc) begin
        issue_en_next  = 1'b1;
        issue_row_next = '0;
        // Job parameters are latched only on the first tile of a job
        if (tile_cnt_reg == '0) begin
          tile_tot_next = (tile_num == '0) ? TILE_W'(1) : tile_num;
          relu_next     = relu_en;
        end
      end
      if (issue_en_reg) begin
        if (issue_row_reg == ROW_W'(M-1)) begin
          issue_en_next  = 1'b0;
          issue_row_next = '0;
        end else begin
          issue_row_next = issue_row_reg + ROW_W'(1);
        end
      end
      if (last_row_done) tile_cnt_next = tile_cnt_reg + TILE_W'(1);
      if (out_hs) begin
        if (out_col_last) begin
          out_col_next = '0;
          out_row_next = out_row_last ? '0 : out_row_reg + ROW_W'(1);
        end else begin
          out_col_next = out_col_reg + COL_W'(1);
        end
      end
      if (out_end) tile_cnt_next = '0;
    end
  end

  // Operand buffers: writable only while idle
  always_ff @(posedge clk) begin
    if (w_we && state_reg == IDLE && ({1'b0, w_addr} < (WA_W+1)'(K*N)))
      w_mem[w_addr] <= w_din;
    if (fm_we && state_reg == IDLE && ({1'b0, fm_addr} < (FA_W+1)'(M*K)))
      fm_mem[fm_addr] <= fm_din;
  end

  // Stage 0: feature row read; stage 1: K*N products
  always_ff @(posedge clk) begin
    for (int k = 0; k < K; k++) begin
      fm_row_reg[k] <= fm_mem[FA_W'(int'(issue_row_reg) * K + k)];
      for (int n = 0; n < N; n++)
        prod_reg[k][n] <= fm_row_reg[k] * w_mem[WA_W'(k * N + n)];
    end
  end

  // Stage 2: reduce over k and accumulate (first tile overwrites stale contents)
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col_sum
      logic signed [ACC_W-1:0] col_sum;
      always_comb begin
        col_sum = '0;
        for (int k = 0; k < K; k++)
          col_sum = col_sum + {{(ACC_W-PROD_W){prod_reg[k][gi][PROD_W-1]}}, prod_reg[k][gi]};
      end
      assign acc_wr_row[gi*ACC_W +: ACC_W] = (tile_cnt_reg == '0) ? col_sum
                                             : acc_rd_reg[gi*ACC_W +: ACC_W] + col_sum;
    end
  endgenerate

  always_comb begin
    if (s0_valid_reg)
      acc_rd_addr = s0_row_reg;
    else if (out_hs && out_col_last)
      acc_rd_addr = out_row_next;
    else
      acc_rd_addr = out_row_reg;
  end

  always_ff @(posedge clk) begin
    if (s1_valid_reg) acc_mem[s1_row_reg] <= acc_wr_row;
    // Write-first so a same-row read sees the fresh sum (matters when M == 1)
    if (s1_valid_reg && s1_row_reg == acc_rd_addr)
      acc_rd_reg <= acc_wr_row;
    else
      acc_rd_reg <= acc_mem[acc_rd_addr];
  end

  // Readout post-processing: round/shift, ReLU, saturate
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [ACC_W:0]   acc_shift, acc_post;
  logic signed [OUT_W-1:0] sat_val;

  assign acc_sel = acc_rd_reg[int'(out_col_reg)*ACC_W +: ACC_W];

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (SHIFT-1);
      logic signed [ACC_W:0] acc_rnd;
      assign acc_rnd   = $signed({acc_sel[ACC_W-1], acc_sel}) + HALF;
      assign acc_shift = acc_rnd >>> SHIFT;
    end else begin : g_noround
      assign acc_shift = $signed({acc_sel[ACC_W-1], acc_sel});
    end
  endgenerate

  always_comb begin
    acc_post = (relu_reg && acc_shift[ACC_W]) ? '0 : acc_shift;
    if (acc_post > OUT_MAX)
      sat_val = OUT_MAX[OUT_W-1:0];
    else if (acc_post < OUT_MIN)
      sat_val = OUT_MIN[OUT_W-1:0];
    else
      sat_val = acc_post[OUT_W-1:0];
  end

  always_comb begin
    busy      = (state_reg == COMPUTE);
    tile_done = last_row_done && !clear;
    out_valid = (state_reg == OUTPUT);
    out_last  = out_valid && out_row_last && out_col_last;
    out_data  = out_valid ? sat_val : '0;
  end

endmodule

// File: tb/tb_matrix_mult_tile_acc.sv
// Directed bench for matrix_mult_tile_acc: timing, accumulation, saturation, ReLU,
// rounding shift (second instance with SHIFT=2), stalls, clear and async reset.
module tb_matrix_mult_tile_acc;
  localparam int M = 4, K = 3, N = 3;

  logic clk = 1'b0;
  logic rst, w_we, fm_we, relu_en, start, clear, out_ready;
  logic [3:0] w_addr, fm_addr, tile_num;
  logic signed [7:0] w_din, fm_din;
  logic busy, tile_done, out_valid, out_last;
  logic signed [15:0] out_data;
  logic busy_sh, tile_done_sh, out_valid_sh, out_last_sh;
  logic signed [15:0] out_data_sh;

  int n_assert = 0, n_fail = 0;
  int td_cnt = 0;
  int exp_v [12];
  int exp_sh [12];
  bit chk_sh;

  always #5 clk = ~clk;
  always @(posedge clk) if (tile_done) td_cnt <= td_cnt + 1;

  matrix_mult_tile_acc u_dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_din(w_din),
    .fm_we(fm_we), .fm_addr(fm_addr), .fm_din(fm_din), .tile_num(tile_num),
    .relu_en(relu_en), .start(start), .clear(clear), .busy(busy),
    .tile_done(tile_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  matrix_mult_tile_acc #(.SHIFT(2)) u_dut_sh (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_din(w_din),
    .fm_we(fm_we), .fm_addr(fm_addr), .fm_din(fm_din), .tile_num(tile_num),
    .relu_en(relu_en), .start(start), .clear(clear), .busy(busy_sh),
    .tile_done(tile_done_sh), .out_valid(out_valid_sh), .out_ready(out_ready),
    .out_data(out_data_sh), .out_last(out_last_sh)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int a, input int v);
    w_we = 1'b1; w_addr = 4'(a); w_din = 8'(v);
    tick();
    w_we = 1'b0;
  endtask

  task automatic wr_fm(input int a, input int v);
    fm_we = 1'b1; fm_addr = 4'(a); fm_din = 8'(v);
    tick();
    fm_we = 1'b0;
  endtask

  task automatic load_w_ident();
    for (int k = 0; k < K; k++)
      for (int n = 0; n < N; n++) wr_w(k*N + n, (k == n) ? 1 : 0);
  endtask

  task automatic load_w_all(input int v);
    for (int a = 0; a < K*N; a++) wr_w(a, v);
  endtask

  task automatic load_fm_ramp();
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) wr_fm(m*K + k, 3*m + k + 1);
  endtask

  task automatic load_fm_all(input int v);
    for (int a = 0; a < M*K; a++) wr_fm(a, v);
  endtask

  task automatic set_exp_ramp(input int scale);
    for (int i = 0; i < 12; i++) exp_v[i] = scale * (i + 1);
  endtask

  // start in cycle t; checks busy at t+1, tile_done only at t+M+2, valid at t+M+3
  task automatic run_tile(input bit fin, input string tag);
    start = 1'b1;
    chk({tag, "_busy_pre"}, busy, 0);
    tick();
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    repeat (4) tick();
    chk({tag, "_td_early"}, tile_done, 0);
    tick();
    chk({tag, "_td"}, tile_done, 1);
    chk({tag, "_valid_early"}, out_valid, 0);
    tick();
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_td_off"}, tile_done, 0);
    chk({tag, "_valid"}, out_valid, fin);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_v%0d", tag, i), out_valid, 1);
      chk($sformatf("%s_d%0d", tag, i), out_data, exp_v[i]);
      chk($sformatf("%s_l%0d", tag, i), out_last, (i == 11) ? 1 : 0);
      if (chk_sh) begin
        chk($sformatf("%s_sh_d%0d", tag, i), out_data_sh, exp_sh[i]);
        chk($sformatf("%s_sh_l%0d", tag, i), out_last_sh, (i == 11) ? 1 : 0);
      end
      tick();
    end
    chk({tag, "_valid_drop"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int td0, idx;
    logic [39:0] pat;
    rst = 1'b1; w_we = 0; fm_we = 0; w_addr = 0; fm_addr = 0; w_din = 0; fm_din = 0;
    tile_num = 4'd1; relu_en = 0; start = 0; clear = 0; out_ready = 0; chk_sh = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    tick();

    // Identity weights, ramp features, single tile
    load_w_ident();
    load_fm_ramp();
    set_exp_ramp(1);
    run_tile(1'b1, "t1");
    drain("t1");

    // Two tiles accumulate -> doubled outputs, two tile_done pulses
    tile_num = 4'd2;
    td0 = td_cnt;
    run_tile(1'b0, "t2a");
    run_tile(1'b1, "t2b");
    set_exp_ramp(2);
    drain("t2");
    chk("t2_td_pulses", td_cnt - td0, 2);

    // start and weight write during busy are ignored
    tile_num = 4'd1;
    set_exp_ramp(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; w_we = 1'b1; w_addr = 4'd0; w_din = 8'sd5;
    tick();
    start = 1'b0; w_we = 1'b0;
    chk("t6_busy", busy, 1);
    repeat (3) tick();
    chk("t6_td", tile_done, 1);
    tick();
    chk("t6_valid", out_valid, 1);
    drain("t6");
    chk("t6_idle_busy", busy, 0);

    // clear at start+2 aborts; next job begins at tile 0
    tile_num = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t7_busy_clr", busy, 0);
    chk("t7_td_clr", tile_done, 0);
    repeat (6) tick();
    chk("t7_no_valid", out_valid, 0);
    tile_num = 4'd1;
    run_tile(1'b1, "t7");
    drain("t7");

    // Random-looking out_ready stalls: no loss/duplication, stable when stalled
    pat = 40'hA5_C3_96_6D_B4;
    run_tile(1'b1, "t5");
    idx = 0;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      out_ready = pat[c];
      chk($sformatf("t5_v_c%0d", c), out_valid, 1);
      chk($sformatf("t5_d_c%0d", c), out_data, exp_v[idx]);
      chk($sformatf("t5_l_c%0d", c), out_last, (idx == 11) ? 1 : 0);
      if (out_ready) idx++;
      tick();
    end
    out_ready = 1'b0;
    chk("t5_handshakes", idx, 12);
    chk("t5_valid_drop", out_valid, 0);

    // Async reset in OUTPUT clears outputs immediately
    run_tile(1'b1, "t8");
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("t8_pre_data", out_data, 3);
    rst = 1'b1;
    #1;
    chk("t8_rst_valid", out_valid, 0);
    chk("t8_rst_data", out_data, 0);
    chk("t8_rst_last", out_last, 0);
    chk("t8_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("t8_after_valid", out_valid, 0);

    // Saturation high: 3*127*127 = 48387
    chk_sh = 1'b1;
    load_w_all(127);
    load_fm_all(127);
    for (int i = 0; i < 12; i++) begin exp_v[i] = 32767; exp_sh[i] = 12097; end
    run_tile(1'b1, "sat_hi");
    drain("sat_hi");

    // Saturation low: 3*-128*127 = -48768
    load_fm_all(-128);
    for (int i = 0; i < 12; i++) begin exp_v[i] = -32768; exp_sh[i] = -12192; end
    run_tile(1'b1, "sat_lo");
    drain("sat_lo");

    // ReLU clamps negatives
    relu_en = 1'b1;
    for (int i = 0; i < 12; i++) begin exp_v[i] = 0; exp_sh[i] = 0; end
    run_tile(1'b1, "relu");
    drain("relu");
    relu_en = 1'b0;

    // Rounding shift: accumulators 6 and -6 -> 2 and -1 with SHIFT=2
    load_w_ident();
    load_fm_all(0);
    wr_fm(0, 6);
    wr_fm(1, -6);
    for (int i = 0; i < 12; i++) begin exp_v[i] = 0; exp_sh[i] = 0; end
    exp_v[0] = 6;  exp_v[1] = -6;
    exp_sh[0] = 2; exp_sh[1] = -1;
    run_tile(1'b1, "shift");
    drain("shift");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
